// File: rtl/phy_rx_pkg.sv
// Shared types and constants for the PHY receive path.
// Holds the aligner FSM states and the standard comma words.
package phy_rx_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

    localparam logic [7:0] COMMA_8B  = 8'hBC;
    localparam logic [9:0] COMMA_10B = 10'h17C;

    // Lane pointer width; a single lane still needs one bit.
    function automatic int lp_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/phy_rx_deser_lanes_if.sv
// Serial-in / parallel-lanes-out bundle of the receive path.
// master is the serial source side, slave is the deserialiser.
interface phy_rx_deser_lanes_if #(
    parameter int WIDTH   = 8,
    parameter int N_LANES = 4
);
    logic                       data_in;
    logic [N_LANES*WIDTH-1:0]   data_out;
    logic [N_LANES-1:0]         valid_out;
    logic                       active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active
    );
endinterface

// File: rtl/phy_comma_aligner.sv
// Serial shift register, bit counter and comma hunt/align/lock FSM.
// Presents the boundary word combinationally with a strobe once locked.
module phy_comma_aligner
    import phy_rx_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] COMMA    = COMMA_8B,
    parameter int               LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_in,
    output logic [WIDTH-1:0] word,
    output logic             word_stb,
    output logic             is_comma,
    output logic             active
);

    localparam int BW = $clog2(WIDTH);
    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam logic [BW-1:0] BMAX = BW'(WIDTH - 1);
    localparam logic [CW-1:0] CMAX = CW'(LOCK_CNT);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [CW-1:0]    ccnt_q, ccnt_d;
    rx_state_e        state_q, state_d;
    logic             active_q, active_d;
    logic             bnd;
    logic             hit;

    always_comb begin
        sr_d    = {sr_q[WIDTH-2:0], data_in};
        bnd     = (bcnt_q == BMAX);
        hit     = (sr_d == COMMA);
        bcnt_d  = bnd ? '0 : bcnt_q + 1'b1;
        ccnt_d  = ccnt_q;
        state_d = state_q;
        unique case (state_q)
            HUNT: begin
                // A match anywhere defines the word phase.
                if (hit) begin
                    bcnt_d  = '0;
                    ccnt_d  = CW'(1);
                    state_d = (LOCK_CNT == 1) ? LOCKED : ALIGN;
                end
            end
            ALIGN: begin
                if (bnd) begin
                    if (hit) begin
                        ccnt_d = (ccnt_q == CMAX) ? ccnt_q
                                                  : ccnt_q + 1'b1;
                        if (ccnt_d == CMAX) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        ccnt_d  = '0;
                        state_d = HUNT;
                    end
                end
            end
            LOCKED: begin
                state_d = LOCKED;
            end
            default: begin
                state_d = HUNT;
            end
        endcase
        active_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q     <= '0;
            bcnt_q   <= '0;
            ccnt_q   <= '0;
            state_q  <= HUNT;
            active_q <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            bcnt_q   <= bcnt_d;
            ccnt_q   <= ccnt_d;
            state_q  <= state_d;
            active_q <= active_d;
        end
    end

    assign word     = sr_d;
    assign word_stb = (state_q == LOCKED) && bnd;
    assign is_comma = hit;
    assign active   = active_q;

endmodule

// File: rtl/phy_rx_deser_lanes.sv
// Receive deserialiser: comma alignment then round-robin lane fan-out.
// Commas are idles and restart the next frame at lane 0.
module phy_rx_deser_lanes
    import phy_rx_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               N_LANES  = 4,
    parameter logic [WIDTH-1:0] COMMA    = COMMA_8B,
    parameter int               LOCK_CNT = 4
) (
    input  logic               clk,
    input  logic               reset,
    phy_rx_deser_lanes_if.slave bus
);

    localparam int LPW = lp_bits(N_LANES);
    localparam logic [LPW-1:0] LP_MAX = LPW'(N_LANES - 1);

    logic [WIDTH-1:0]         word;
    logic                     word_stb;
    logic                     is_comma;
    logic                     active;

    logic [LPW-1:0]           lp_q, lp_d;
    logic [N_LANES*WIDTH-1:0] dout_q, dout_d;
    logic [N_LANES-1:0]       vld_q, vld_d;

    phy_comma_aligner #(
        .WIDTH    (WIDTH),
        .COMMA    (COMMA),
        .LOCK_CNT (LOCK_CNT)
    ) u_align (
        .clk      (clk),
        .rst_n    (reset),
        .data_in  (bus.data_in),
        .word     (word),
        .word_stb (word_stb),
        .is_comma (is_comma),
        .active   (active)
    );

    always_comb begin
        lp_d   = lp_q;
        dout_d = dout_q;
        vld_d  = '0;
        if (word_stb) begin
            if (is_comma) begin
                lp_d = '0;
            end else begin
                for (int k = 0; k < N_LANES; k++) begin
                    if (lp_q == LPW'(k)) begin
                        dout_d[k*WIDTH +: WIDTH] = word;
                        vld_d[k]                 = 1'b1;
                    end
                end
                lp_d = (lp_q == LP_MAX) ? '0 : lp_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lp_q   <= '0;
            dout_q <= '0;
            vld_q  <= '0;
        end else begin
            lp_q   <= lp_d;
            dout_q <= dout_d;
            vld_q  <= vld_d;
        end
    end

    assign bus.data_out  = dout_q;
    assign bus.valid_out = vld_q;
    assign bus.active    = active;

endmodule

// File: tb/tb_phy_rx_deser_lanes.sv
// Scoreboard bench for phy_rx_deser_lanes in two parameter sets.
// Stimulus queues expected lane writes; a negedge monitor pops them.
module tb_phy_rx_deser_lanes;
    import phy_rx_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    phy_rx_deser_lanes_if #(.WIDTH(8),  .N_LANES(4)) ia ();
    phy_rx_deser_lanes_if #(.WIDTH(10), .N_LANES(3)) ib ();

    phy_rx_deser_lanes #(
        .WIDTH(8), .N_LANES(4), .COMMA(COMMA_8B), .LOCK_CNT(4)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ia)
    );

    phy_rx_deser_lanes #(
        .WIDTH(10), .N_LANES(3), .COMMA(COMMA_10B), .LOCK_CNT(2)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ib)
    );

    typedef struct {
        int         id;
        int         lane;
        logic [9:0] data;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          exp_lp[2];
    logic [31:0] model[2];
    int          last_v[2];
    int          cyc = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic mon(input int id, input int w,
                       input logic [31:0] dout, input logic [3:0] vld);
        exp_t        e;
        int          lane;
        logic [31:0] m;
        if (vld == 4'd0) return;
        lane = -1;
        for (int k = 0; k < 4; k++) if (vld[k]) lane = k;
        chk("onehot", 32'($countones(vld)), 32'd1);
        chk("gap", 32'((cyc - last_v[id]) >= w), 32'd1);
        last_v[id] = cyc;
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected: dut%0d lane %0d got %h want none",
                     id, lane, dout);
            return;
        end
        e = q.pop_front();
        chk("dut", 32'(id), 32'(e.id));
        chk("lane", 32'(lane), 32'(e.lane));
        m = model[e.id];
        for (int b = 0; b < w; b++) m[e.lane*w + b] = e.data[b];
        model[e.id] = m;
        chk("lanes", dout, m);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            model[0]  = '0;
            model[1]  = '0;
            last_v[0] = -100;
            last_v[1] = -100;
        end else begin
            mon(0, 8, ia.data_out, ia.valid_out);
            mon(1, 10, {2'b00, ib.data_out}, {1'b0, ib.valid_out});
        end
    end

    task automatic send(input int id, input logic [9:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            if (id == 0) ia.data_in = v[i];
            else         ib.data_in = v[i];
        end
    endtask

    task automatic word(input int id, input logic [9:0] v);
        int         w;
        int         nl;
        logic [9:0] c;
        w  = (id != 0) ? 10 : 8;
        nl = (id != 0) ? 3 : 4;
        c  = (id != 0) ? COMMA_10B : {2'b00, COMMA_8B};
        if (v == c) begin
            exp_lp[id] = 0;
        end else begin
            q.push_back('{id: id, lane: exp_lp[id], data: v});
            exp_lp[id] = (exp_lp[id] == nl - 1) ? 0 : exp_lp[id] + 1;
        end
        send(id, v, w);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic go_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        exp_lp[0] = 0;
        exp_lp[1] = 0;
        ia.data_in = 1'b0;
        ib.data_in = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_act_a"}, 32'(ia.active), 32'd0);
        chk({tag, "_vld_a"}, 32'(ia.valid_out), 32'd0);
        chk({tag, "_dat_a"}, ia.data_out, 32'd0);
        chk({tag, "_act_b"}, 32'(ib.active), 32'd0);
        chk({tag, "_vld_b"}, 32'(ib.valid_out), 32'd0);
        chk({tag, "_dat_b"}, 32'(ib.data_out), 32'd0);
    endtask

    initial begin
        exp_lp[0]  = 0;
        exp_lp[1]  = 0;
        ia.data_in = 1'b0;
        ib.data_in = 1'b0;
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            ia.data_in = 1'($urandom);
            ib.data_in = 1'($urandom);
        end
        #1 chk_idle("rst");
        ia.data_in = 1'b0;
        ib.data_in = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;

        // Lock at a 3-bit offset, then round-robin and comma restart.
        send(0, 10'b101, 3);
        repeat (3) send(0, 10'h0BC, 8);
        after_edge();
        chk("lock_early", 32'(ia.active), 32'd0);
        send(0, 10'h0BC, 8);
        after_edge();
        chk("lock", 32'(ia.active), 32'd1);
        word(0, 10'h011);
        word(0, 10'h022);
        word(0, 10'h033);
        word(0, 10'h044);
        word(0, 10'h055);
        word(0, 10'h0BC);
        word(0, 10'h011);
        word(0, 10'h022);
        word(0, 10'h0BC);
        word(0, 10'h033);
        after_edge();
        chk("stay_lock", 32'(ia.active), 32'd1);

        // Asynchronous abort half-way through a word.
        send(0, 10'h6, 4);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk_idle("async");
        exp_lp[0] = 0;
        exp_lp[1] = 0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;

        // Two commas then junk must fall back to a fresh hunt.
        send(0, 10'h0BC, 8);
        send(0, 10'h0BC, 8);
        send(0, 10'h000, 8);
        after_edge();
        chk("broken", 32'(ia.active), 32'd0);
        repeat (3) send(0, 10'h0BC, 8);
        after_edge();
        chk("relock_early", 32'(ia.active), 32'd0);
        send(0, 10'h0BC, 8);
        after_edge();
        chk("relock", 32'(ia.active), 32'd1);
        word(0, 10'h077);
        word(0, 10'h088);
        go_reset();

        // Ten-bit words over three lanes, lock after two commas.
        send(1, COMMA_10B, 10);
        after_edge();
        chk("b_lock_early", 32'(ib.active), 32'd0);
        send(1, COMMA_10B, 10);
        after_edge();
        chk("b_lock", 32'(ib.active), 32'd1);
        chk("b_a_idle", 32'(ia.active), 32'd0);
        word(1, 10'd1);
        word(1, 10'd2);
        word(1, 10'd3);
        word(1, 10'd4);
        go_reset();

        repeat (4) @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
